// File: rtl/output_layer_argmax.sv
// Output layer of a small MLP: ten parallel multiply-accumulate lanes, a bias add,
// then a sequential argmax scan that reports the winning class and its score.
module output_layer_argmax #(
  parameter int N_HIDDEN   = 30,
  parameter int BIAS_SHIFT = 7
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic signed [7:0]  x_i,
  input  logic signed [7:0]  w0_i,
  input  logic signed [7:0]  w1_i,
  input  logic signed [7:0]  w2_i,
  input  logic signed [7:0]  w3_i,
  input  logic signed [7:0]  w4_i,
  input  logic signed [7:0]  w5_i,
  input  logic signed [7:0]  w6_i,
  input  logic signed [7:0]  w7_i,
  input  logic signed [7:0]  w8_i,
  input  logic signed [7:0]  w9_i,
  input  logic signed [7:0]  bias0_i,
  input  logic signed [7:0]  bias1_i,
  input  logic signed [7:0]  bias2_i,
  input  logic signed [7:0]  bias3_i,
  input  logic signed [7:0]  bias4_i,
  input  logic signed [7:0]  bias5_i,
  input  logic signed [7:0]  bias6_i,
  input  logic signed [7:0]  bias7_i,
  input  logic signed [7:0]  bias8_i,
  input  logic signed [7:0]  bias9_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [3:0]         class_o,
  output logic signed [23:0] max_score_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_BIAS,
    S_ARGMAX,
    S_DONE
  } state_e;

  localparam logic [9:0] LastTerm = 10'(N_HIDDEN - 1);
  localparam logic [3:0] LastIdx  = 4'd9;

  logic signed [7:0]  w[10];
  logic signed [7:0]  b[10];
  logic signed [15:0] prod[10];
  logic signed [23:0] acc_q[10];
  logic signed [23:0] acc_d[10];

  state_e             state_q;
  logic [9:0]         cnt_q;
  logic [3:0]         idx_q;
  logic signed [23:0] best_q;
  logic signed [23:0] best_d;
  logic [3:0]         best_idx_q;
  logic [3:0]         best_idx_d;
  logic signed [23:0] cand;

  logic               in_ready_q;
  logic               busy_q;
  logic               done_q;
  logic [3:0]         class_q;
  logic signed [23:0] max_q;

  assign w[0] = w0_i;
  assign w[1] = w1_i;
  assign w[2] = w2_i;
  assign w[3] = w3_i;
  assign w[4] = w4_i;
  assign w[5] = w5_i;
  assign w[6] = w6_i;
  assign w[7] = w7_i;
  assign w[8] = w8_i;
  assign w[9] = w9_i;

  assign b[0] = bias0_i;
  assign b[1] = bias1_i;
  assign b[2] = bias2_i;
  assign b[3] = bias3_i;
  assign b[4] = bias4_i;
  assign b[5] = bias5_i;
  assign b[6] = bias6_i;
  assign b[7] = bias7_i;
  assign b[8] = bias8_i;
  assign b[9] = bias9_i;

  // Operands are sign-extended to 16 bits so the truncated product is the exact signed result.
  always_comb begin
    for (int unsigned k = 0; k < 10; k++) begin
      prod[k] = $signed({{8{x_i[7]}}, x_i}) * $signed({{8{w[k][7]}}, w[k]});
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < 10; k++) begin
      acc_d[k] = acc_q[k];
      case (state_q)
        S_IDLE: begin
          if (start_i) acc_d[k] = '0;
        end
        S_ACCUM: begin
          if (in_valid_i) acc_d[k] = acc_q[k] + {{8{prod[k][15]}}, prod[k]};
        end
        S_BIAS: begin
          acc_d[k] = acc_q[k] + ({{16{b[k][7]}}, b[k]} << BIAS_SHIFT);
        end
        default: acc_d[k] = acc_q[k];
      endcase
    end
  end

  // Index 0 seeds the running maximum; strict '>' keeps the lowest index on ties.
  always_comb begin
    cand       = acc_q[idx_q];
    best_d     = best_q;
    best_idx_d = best_idx_q;
    if ((idx_q == 4'd0) || (cand > best_q)) begin
      best_d     = cand;
      best_idx_d = idx_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      class_q    <= '0;
      max_q      <= '0;
      for (int unsigned k = 0; k < 10; k++) acc_q[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < 10; k++) acc_q[k] <= acc_d[k];
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            state_q    <= S_ACCUM;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            in_ready_q <= 1'b1;
          end
        end
        S_ACCUM: begin
          if (in_valid_i) begin
            cnt_q <= cnt_q + 10'd1;
            if (cnt_q == LastTerm) begin
              state_q    <= S_BIAS;
              in_ready_q <= 1'b0;
            end
          end
        end
        S_BIAS: begin
          state_q <= S_ARGMAX;
          idx_q   <= '0;
        end
        S_ARGMAX: begin
          best_q     <= best_d;
          best_idx_q <= best_idx_d;
          idx_q      <= idx_q + 4'd1;
          if (idx_q == LastIdx) begin
            state_q <= S_DONE;
            class_q <= best_idx_d;
            max_q   <= best_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q    <= S_IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign class_o     = class_q;
  assign max_score_o = max_q;

endmodule

// File: tb/tb_output_layer_argmax.sv
// Scoreboard bench for output_layer_argmax: directed inferences push expected results,
// a negedge monitor pops and compares whenever done is presented.
module tb_output_layer_argmax;

  typedef struct packed {
    logic [3:0]         cls;
    logic signed [23:0] score;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic               in_valid = 1'b0;
  logic signed [7:0]  x = '0;
  logic signed [7:0]  w[10];
  logic signed [7:0]  b[10];
  logic               in_ready;
  logic               busy;
  logic               done;
  logic [3:0]         cls;
  logic signed [23:0] max_score;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   done_cnt = 0;
  int   last_pres = 0;
  exp_t sb[$];
  exp_t mon_e;

  output_layer_argmax #(
    .N_HIDDEN  (30),
    .BIAS_SHIFT(7)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .x_i        (x),
    .w0_i       (w[0]),
    .w1_i       (w[1]),
    .w2_i       (w[2]),
    .w3_i       (w[3]),
    .w4_i       (w[4]),
    .w5_i       (w[5]),
    .w6_i       (w[6]),
    .w7_i       (w[7]),
    .w8_i       (w[8]),
    .w9_i       (w[9]),
    .bias0_i    (b[0]),
    .bias1_i    (b[1]),
    .bias2_i    (b[2]),
    .bias3_i    (b[3]),
    .bias4_i    (b[4]),
    .bias5_i    (b[5]),
    .bias6_i    (b[6]),
    .bias7_i    (b[7]),
    .bias8_i    (b[8]),
    .bias9_i    (b[9]),
    .busy_o     (busy),
    .done_o     (done),
    .class_o    (cls),
    .max_score_o(max_score)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic signed [63:0] act, input logic signed [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no pending result", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("class", cls, mon_e.cls);
        check("max_score", $signed(max_score), $signed(mon_e.score));
        check("done_latency", cyc - last_pres, 12);
      end
    end
  end

  task automatic do_start(input logic [3:0] ec, input int es);
    exp_t e;
    e.cls   = ec;
    e.score = 24'(es);
    sb.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("in_ready_after_start", in_ready, 1);
    check("busy_after_start", busy, 1);
  endtask

  task automatic send_term(input bit extra_start);
    int t = 0;
    in_valid = 1'b1;
    start    = extra_start;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got in_ready=0 for %0d cycles, expected 1", t);
    end
    last_pres = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic send_terms(input int n, input bit gaps, input int start_at);
    for (int i = 0; i < n; i++) begin
      if (gaps && (i % 7 == 3)) repeat (2) @(negedge clk);
      send_term(i == start_at);
    end
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got done=0 for %0d cycles, expected 1", t);
    end
  endtask

  task automatic run(input logic [3:0] ec, input int es, input bit gaps);
    do_start(ec, es);
    send_terms(30, gaps, -1);
    wait_done();
    @(negedge clk);
    check("busy_after_done", busy, 0);
  endtask

  task automatic set_all(input logic signed [7:0] xv, input logic signed [7:0] wv, input logic signed [7:0] bv);
    x = xv;
    for (int k = 0; k < 10; k++) begin
      w[k] = wv;
      b[k] = bv;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1);
  end

  initial begin
    set_all(8'sd0, 8'sd0, 8'sd0);
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_class", cls, 0);
    check("rst_max_score", $signed(max_score), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_wait_busy", busy, 0);

    // x=1, wk=k: acc_k = 30k
    set_all(8'sd1, 8'sd0, 8'sd0);
    for (int k = 0; k < 10; k++) w[k] = 8'(k);
    run(4'd9, 270, 1'b0);

    // only bias3 nonzero: 5<<7
    set_all(8'sd7, 8'sd0, 8'sd0);
    b[3] = 8'sd5;
    run(4'd3, 640, 1'b0);

    // all lanes equal: 30*3*2 + 128
    set_all(8'sd3, 8'sd2, 8'sd1);
    run(4'd0, 308, 1'b0);

    // 30*16384 - 128, with in_valid gaps
    set_all(8'h80, 8'sd0, 8'hFF);
    w[5] = 8'h80;
    run(4'd5, 491392, 1'b1);

    // acc_k = -30k, bias0 drags lane 0 to -256
    set_all(-8'sd1, 8'sd0, 8'sd0);
    for (int k = 0; k < 10; k++) w[k] = 8'(k);
    b[0] = -8'sd2;
    run(4'd1, -30, 1'b0);

    // tie between lanes 2 and 7
    set_all(8'sd1, 8'sd0, 8'sd0);
    w[2] = 8'sd4;
    w[7] = 8'sd4;
    run(4'd2, 120, 1'b0);

    // abort at the 15th term
    set_all(8'sd1, 8'sd0, 8'sd0);
    for (int k = 0; k < 10; k++) w[k] = 8'(k);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_terms(14, 1'b0, -1);
    in_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("abort_in_ready", in_ready, 0);
    check("abort_busy", busy, 0);
    check("abort_class", cls, 0);
    check("abort_max_score", $signed(max_score), 0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    check("abort_done", done, 0);
    repeat (15) @(negedge clk);
    check("abort_idle_busy", busy, 0);
    run(4'd9, 270, 1'b0);

    // stray in_valid in IDLE, start during ACCUM, ARGMAX and DONE
    set_all(8'sd5, 8'sd5, 8'sd0);
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    check("idle_in_valid_busy", busy, 0);
    check("idle_in_valid_ready", in_ready, 0);
    set_all(8'sd2, 8'sd0, 8'sd0);
    for (int k = 0; k < 10; k++) w[k] = 8'(k - 5);
    do_start(4'd9, 240);
    send_terms(30, 1'b0, 10);
    repeat (3) @(negedge clk);
    start    = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    check("argmax_busy", busy, 1);
    check("argmax_in_ready", in_ready, 0);
    wait_done();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("done_start_busy", busy, 0);
    check("done_start_ready", in_ready, 0);
    repeat (20) @(negedge clk);

    check("done_count", done_cnt, 8);
    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
